// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a 4-entry byte FIFO, sharing the receiver's 4x-per-bit timebase.
// Frames go out LSB-first; queued bytes follow each other with no idle gap between frames.
module uart_tx #(
    parameter int CLOCK_DIVIDE = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_write,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       is_transmitting,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx_done,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [12:0] DIV_RELOAD = 13'(CLOCK_DIVIDE - 1);

    state_t     state;
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic [2:0] count_next;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic [12:0] div_cnt;
    logic [1:0] quarter;

    logic write_ok;
    logic pop;
    logic quarter_tick;
    logic bit_end;

    assign write_ok     = tx_write && !fifo_full;
    assign quarter_tick = (div_cnt == 13'd0);
    assign bit_end      = quarter_tick && (quarter == 2'd3);

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            STOP:    pop = bit_end && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({write_ok, pop})
            2'b10:   count_next = count + 3'd1;
            2'b01:   count_next = count - 3'd1;
            default: count_next = count;
        endcase
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            fifo_mem[wr_ptr] <= tx_byte;
        end
    end

    // Flags are registered from the next count so they track the queue after every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            count      <= 3'd0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count      <= count_next;
            fifo_full  <= (count_next == 3'd4);
            fifo_empty <= (count_next == 3'd0);
            overflow   <= tx_write && fifo_full;
        end
    end

    // Frame sequencer; the later timer assignments on START entry override the free-running update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
            tx_done         <= 1'b0;
            shift           <= 8'd0;
            bit_idx         <= 3'd0;
            div_cnt         <= DIV_RELOAD;
            quarter         <= 2'd0;
        end else begin
            tx_done <= 1'b0;

            if (quarter_tick) begin
                div_cnt <= DIV_RELOAD;
                quarter <= quarter + 2'd1;
            end else begin
                div_cnt <= div_cnt - 13'd1;
            end

            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    div_cnt <= DIV_RELOAD;
                    quarter <= 2'd0;
                    if (pop) begin
                        shift           <= fifo_mem[rd_ptr];
                        state           <= START;
                        tx              <= 1'b0;
                        is_transmitting <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        if (pop) begin
                            shift   <= fifo_mem[rd_ptr];
                            state   <= START;
                            tx      <= 1'b0;
                            div_cnt <= DIV_RELOAD;
                            quarter <= 2'd0;
                        end else begin
                            state           <= IDLE;
                            is_transmitting <= 1'b0;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    tx              <= 1'b1;
                    is_transmitting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLOCK_DIVIDE=4 (16-cycle bits, 160-cycle frames).
// Line samples are taken on the falling clock edge and compared against hand-built 8N1 waveforms.
module tb_uart_tx;

    localparam int DIV       = 4;
    localparam int FRAME_CYC = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_write = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx;
    logic       is_transmitting;
    logic       fifo_full;
    logic       fifo_empty;
    logic       tx_done;
    logic       overflow;

    int checks = 0;
    int passed = 0;
    int done_count = 0;
    logic line_s [0:1023];
    logic busy_s [0:1023];

    uart_tx #(.CLOCK_DIVIDE(DIV)) dut (
        .clk(clk),
        .rst(rst),
        .tx_write(tx_write),
        .tx_byte(tx_byte),
        .tx(tx),
        .is_transmitting(is_transmitting),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .tx_done(tx_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_count++;
    end

    // Expected line level k cycles into a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int idx;
        idx = k / 16;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx); else passed++;
        checks++; if (fifo_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty); else passed++;
        checks++; if (fifo_full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); else passed++;
        checks++; if (is_transmitting !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", is_transmitting); else passed++;
        checks++; if (tx_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", tx_done); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int d0, errs;
        logic [7:0] dec;
        d0 = done_count;
        @(negedge clk); tx_write = 1'b1; tx_byte = 8'hA5;
        @(negedge clk); tx_write = 1'b0;
        checks++; if (fifo_empty !== 1'b0) $display("[TB] FAIL single_queued: got %b expected 0", fifo_empty); else passed++;
        checks++; if (tx !== 1'b1) $display("[TB] FAIL single_pre_start: got %b expected 1", tx); else passed++;
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk); line_s[k] = tx; busy_s[k] = is_transmitting;
        end
        errs = 0;
        for (int k = 0; k < FRAME_CYC; k++)
            if (line_s[k] !== exp_line(8'hA5, k) || busy_s[k] !== 1'b1) errs++;
        checks++; if (errs != 0) $display("[TB] FAIL single_frame: got %0d bad cycles expected 0", errs); else passed++;
        for (int i = 0; i < 8; i++) dec[i] = line_s[16*(i+1)+8];
        checks++; if (dec !== 8'hA5) $display("[TB] FAIL single_decode: got %h expected a5", dec); else passed++;
        @(negedge clk);
        checks++; if (tx_done !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", tx_done); else passed++;
        checks++; if (is_transmitting !== 1'b0) $display("[TB] FAIL single_busy_fall: got %b expected 0", is_transmitting); else passed++;
        checks++; if (fifo_empty !== 1'b1) $display("[TB] FAIL single_empty: got %b expected 1", fifo_empty); else passed++;
        checks++; if (tx !== 1'b1) $display("[TB] FAIL single_idle_tx: got %b expected 1", tx); else passed++;
        @(negedge clk);
        checks++; if (tx_done !== 1'b0) $display("[TB] FAIL single_done_width: got %b expected 0", tx_done); else passed++;
        checks++; if (done_count - d0 != 1) $display("[TB] FAIL single_done_count: got %0d expected 1", done_count - d0); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bytes [3];
        int d0, errs;
        logic [7:0] dec;
        exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h55;
        d0 = done_count;
        @(negedge clk); tx_write = 1'b1; tx_byte = 8'h00;
        @(negedge clk); tx_byte = 8'hFF;
        for (int k = 0; k < 3*FRAME_CYC; k++) begin
            @(negedge clk); line_s[k] = tx; busy_s[k] = is_transmitting;
            if (k == 0) tx_byte = 8'h55;
            if (k == 1) tx_write = 1'b0;
        end
        for (int f = 0; f < 3; f++) begin
            errs = 0;
            for (int k = 0; k < FRAME_CYC; k++)
                if (line_s[f*FRAME_CYC+k] !== exp_line(exp_bytes[f], k) || busy_s[f*FRAME_CYC+k] !== 1'b1) errs++;
            checks++; if (errs != 0) $display("[TB] FAIL b2b_frame%0d: got %0d bad cycles expected 0", f, errs); else passed++;
            for (int i = 0; i < 8; i++) dec[i] = line_s[f*FRAME_CYC+16*(i+1)+8];
            checks++; if (dec !== exp_bytes[f]) $display("[TB] FAIL b2b_decode%0d: got %h expected %h", f, dec, exp_bytes[f]); else passed++;
        end
        @(negedge clk);
        checks++; if (is_transmitting !== 1'b0) $display("[TB] FAIL b2b_busy_fall: got %b expected 0", is_transmitting); else passed++;
        @(negedge clk);
        checks++; if (done_count - d0 != 3) $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_count - d0); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_bytes [5];
        int errs;
        logic [7:0] dec;
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h81;
        @(negedge clk); tx_write = 1'b1; tx_byte = 8'h11;
        @(negedge clk); tx_byte = 8'h22;
        for (int k = 0; k < 850; k++) begin
            @(negedge clk); line_s[k] = tx; busy_s[k] = is_transmitting;
            case (k)
                0: tx_byte = 8'h33;
                1: tx_byte = 8'h44;
                2: begin
                    checks++; if (fifo_full !== 1'b0) $display("[TB] FAIL ovf_not_full3: got %b expected 0", fifo_full); else passed++;
                    tx_byte = 8'h81;
                end
                3: begin
                    checks++; if (fifo_full !== 1'b1) $display("[TB] FAIL ovf_full4: got %b expected 1", fifo_full); else passed++;
                    checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_early: got %b expected 0", overflow); else passed++;
                    tx_byte = 8'h5A;
                end
                4: begin
                    checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_pulse: got %b expected 1", overflow); else passed++;
                    checks++; if (fifo_full !== 1'b1) $display("[TB] FAIL ovf_still_full: got %b expected 1", fifo_full); else passed++;
                    tx_write = 1'b0;
                end
                5: begin
                    checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_pulse_width: got %b expected 0", overflow); else passed++;
                end
                159: begin
                    tx_write = 1'b1; tx_byte = 8'hC3;
                end
                160: begin
                    checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_pop_edge: got %b expected 1", overflow); else passed++;
                    checks++; if (tx_done !== 1'b1) $display("[TB] FAIL ovf_pop_done: got %b expected 1", tx_done); else passed++;
                    checks++; if (fifo_full !== 1'b0) $display("[TB] FAIL ovf_pop_count: got %b expected 0", fifo_full); else passed++;
                    tx_write = 1'b0;
                end
                800: begin
                    checks++; if (tx_done !== 1'b1) $display("[TB] FAIL ovf_last_done: got %b expected 1", tx_done); else passed++;
                end
                default: ;
            endcase
        end
        for (int f = 0; f < 5; f++) begin
            errs = 0;
            for (int k = 0; k < FRAME_CYC; k++)
                if (line_s[f*FRAME_CYC+k] !== exp_line(exp_bytes[f], k) || busy_s[f*FRAME_CYC+k] !== 1'b1) errs++;
            checks++; if (errs != 0) $display("[TB] FAIL ovf_frame%0d: got %0d bad cycles expected 0", f, errs); else passed++;
            for (int i = 0; i < 8; i++) dec[i] = line_s[f*FRAME_CYC+16*(i+1)+8];
            checks++; if (dec !== exp_bytes[f]) $display("[TB] FAIL ovf_decode%0d: got %h expected %h", f, dec, exp_bytes[f]); else passed++;
        end
        errs = 0;
        for (int k = 800; k < 850; k++)
            if (line_s[k] !== 1'b1 || busy_s[k] !== 1'b0) errs++;
        checks++; if (errs != 0) $display("[TB] FAIL ovf_dropped_not_sent: got %0d busy cycles expected 0", errs); else passed++;
        checks++; if (fifo_empty !== 1'b1) $display("[TB] FAIL ovf_final_empty: got %b expected 1", fifo_empty); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int errs;
        @(negedge clk); tx_write = 1'b1; tx_byte = 8'h00;
        @(negedge clk); tx_byte = 8'h7E;
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            if (k == 0) tx_byte = 8'h3C;
            if (k == 1) tx_write = 1'b0;
        end
        checks++; if (tx !== 1'b0) $display("[TB] FAIL rstmid_bit3_low: got %b expected 0", tx); else passed++;
        checks++; if (fifo_empty !== 1'b0) $display("[TB] FAIL rstmid_queued: got %b expected 0", fifo_empty); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) $display("[TB] FAIL rstmid_async_tx: got %b expected 1", tx); else passed++;
        checks++; if (fifo_empty !== 1'b1) $display("[TB] FAIL rstmid_empty: got %b expected 1", fifo_empty); else passed++;
        checks++; if (is_transmitting !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", is_transmitting); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || is_transmitting !== 1'b0 || fifo_empty !== 1'b1) errs++;
        end
        checks++; if (errs != 0) $display("[TB] FAIL rstmid_stays_idle: got %0d bad cycles expected 0", errs); else passed++;
        @(negedge clk); tx_write = 1'b1; tx_byte = 8'h96;
        @(negedge clk); tx_write = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b0) $display("[TB] FAIL rstmid_new_start: got %b expected 0", tx); else passed++;
        checks++; if (is_transmitting !== 1'b1) $display("[TB] FAIL rstmid_new_busy: got %b expected 1", is_transmitting); else passed++;
        repeat (FRAME_CYC + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for 8N1 frames on the board's UART link, the outbound counterpart to the existing receiver. It uses the same 4x-per-bit timebase, so one `CLOCK_DIVIDE` setting serves both directions. A 4-entry byte FIFO lets game/control logic queue short messages without waiting on the line. Frames are sent LSB-first and back-to-back.

## Interface
- `CLOCK_DIVIDE`, 2604: clock cycles per quarter-bit (100 MHz / (9600 × 4)). Legal range 1..8191. Bit period = 4 × `CLOCK_DIVIDE` cycles.
- `clk` input 1: master clock; all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_write` input 1: write strobe; `tx_byte` is queued on a posedge when `tx_write`=1 and `fifo_full`=0.
- `tx_byte` input 8: byte to queue.
- `tx` output 1: serial line, idle high; registered.
- `is_transmitting` output 1: high while a frame is on the line (state ≠ IDLE).
- `fifo_full` output 1: 4 bytes queued.
- `fifo_empty` output 1: 0 bytes queued.
- `tx_done` output 1: one-cycle pulse at the end of each stop bit.
- `overflow` output 1: one-cycle pulse when a write is dropped because the FIFO is full.

## Operation
- FIFO: 4 × 8, with 2-bit read/write pointers and a 3-bit count (0..4).
  - `fifo_full` = (count==4); `fifo_empty` = (count==0).
  - Pointers wrap 3→0.
  - Acceptance of a write depends only on `fifo_full` as sampled before the edge. A write while full is dropped and pulses `overflow` on the next cycle, even if a pop happens on the same edge.
  - A simultaneous accepted write and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a shift register, clear the timers, and go to START.
  - START: `tx`=0 for 4 quarter-ticks, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for 4 quarter-ticks per bit, then shift right and increment the index. After bit index 7 completes, go to STOP.
  - STOP: `tx`=1 for 4 quarter-ticks. At the end, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START on the same edge (no idle gap); otherwise go to IDLE.
- Timebase:
  - A 13-bit divider counts CLOCK_DIVIDE-1 down to 0; the 0 cycle is one quarter-tick.
  - A 2-bit quarter counter advances a bit on every 4th quarter-tick.
  - Both counters are reloaded on every entry to START, so each bit is exactly 4 × `CLOCK_DIVIDE` cycles long.
  - The divider is held at reload while in IDLE.
- Reset:
  - `tx`=1, state IDLE, FIFO pointers and count = 0.
  - `fifo_empty`=1; `fifo_full`, `is_transmitting`, `tx_done`, `overflow` = 0.
  - Queued data is discarded.
  - A reset mid-frame forces `tx` high immediately (asynchronously). No partial frame resumes after reset is released.

## Timing
- Latency: a write accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. `tx` falls and `is_transmitting` rises after edge N+1.
- Frame length is 40 × `CLOCK_DIVIDE` cycles: start + 8 data + stop, each 4 × `CLOCK_DIVIDE`.
- `tx_done` is high for the single cycle after the final stop-bit quarter-tick.
- Back-to-back frames: the next start bit begins on the same edge as that `tx_done` pulse, so `tx` goes from stop (1) straight to start (0).
- `fifo_full` and `fifo_empty` are registered and reflect count after each edge. A byte popped into the shift register no longer counts toward full.
- `tx_byte` is sampled only on the write edge and need not be held afterwards.

## Test plan
- Single byte, CLOCK_DIVIDE=4: write 0xA5 while idle.
  - `tx` low for 16 cycles starting the cycle after the write.
  - Then bits 1,0,1,0,0,1,0,1 (LSB-first), 16 cycles each.
  - Then high for 16 cycles; `tx_done` pulses once; `is_transmitting` falls; `fifo_empty`=1.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three contiguous 160-cycle frames with no idle cycle between a stop bit and the next start bit.
  - Exactly three `tx_done` pulses.
  - A receiver loopback at the same CLOCK_DIVIDE receives 0x00, 0xFF, 0x55 with no errors.
- Full/overflow: during the first frame, write 5 more bytes.
  - `fifo_full`=1 after the 4th queued byte.
  - The 5th write pulses `overflow` and is never transmitted.
  - Write while full with a simultaneous end-of-stop pop: the write is still dropped.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued.
  - `tx`=1 with no wait for a clock edge; FIFO empty.
  - After release, the line stays idle until a new write.
- Default divider: CLOCK_DIVIDE=2604, write 0x3C; each bit lasts 10416 cycles and the frame lasts 104160 cycles.
